// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoding definitions: mnemonics, opcodes, immediate limits, encoder FSM states.
// The PAD state exists only when LEGV8_ENC_PAD_EN is defined.
package legv8_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_ORR  = 4'd3,
    OP_LDUR = 4'd4,  OP_STUR = 4'd5,  OP_B    = 4'd6,  OP_CBZ  = 4'd7,
    OP_CBNZ = 4'd8,  OP_ADDI = 4'd9,  OP_SUBI = 4'd10, OP_ANDI = 4'd11,
    OP_ORRI = 4'd12, OP_END  = 4'd13
  } op_e;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [5:0]  OPC_B    = 6'b000101;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [7:0]  OPC_CBNZ = 8'b10110101;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
  localparam logic [9:0]  OPC_ANDI = 10'b1001001000;
  localparam logic [9:0]  OPC_ORRI = 10'b1011001000;

  localparam logic        [25:0] I_IMM_MAX  = 26'd4095;
  localparam logic signed [25:0] D_IMM_MIN  = -26'sd256;
  localparam logic signed [25:0] D_IMM_MAX  = 26'sd255;
  localparam logic signed [25:0] CB_IMM_MIN = -26'sd262144;
  localparam logic signed [25:0] CB_IMM_MAX = 26'sd262143;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
`ifdef LEGV8_ENC_PAD_EN
    S_PAD   = 3'd2,
`endif
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_e;

  function automatic logic [31:0] fmt_r(input logic [10:0] opc, input logic [4:0] rm,
                                        input logic [4:0] rn, input logic [4:0] rd);
    return {opc, rm, 6'b000000, rn, rd};
  endfunction

  function automatic logic [31:0] fmt_i(input logic [9:0] opc, input logic [11:0] imm,
                                        input logic [4:0] rn, input logic [4:0] rd);
    return {opc, imm, rn, rd};
  endfunction

  function automatic logic [31:0] fmt_d(input logic [10:0] opc, input logic [8:0] addr,
                                        input logic [4:0] rn, input logic [4:0] rt);
    return {opc, addr, 2'b00, rn, rt};
  endfunction

  function automatic logic [31:0] fmt_cb(input logic [7:0] opc, input logic [18:0] imm,
                                         input logic [4:0] rt);
    return {opc, imm, rt};
  endfunction

endpackage

// File: rtl/legv8_field_pack.sv
// Combinational packer: symbolic instruction -> 32-bit LEGv8 word, plus an illegal flag
// for unknown mnemonics or immediates outside the format's range.
module legv8_field_pack import legv8_pkg::*; (
  input  logic [3:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic signed [25:0] w_simm;
  logic               w_d_bad;
  logic               w_cb_bad;
  logic               w_i_bad;

  assign w_simm   = $signed(imm);
  assign w_d_bad  = (w_simm < D_IMM_MIN) || (w_simm > D_IMM_MAX);
  assign w_cb_bad = (w_simm < CB_IMM_MIN) || (w_simm > CB_IMM_MAX);
  assign w_i_bad  = imm > I_IMM_MAX;

  always_comb begin
    word    = 32'h0;
    illegal = 1'b0;
    case (op_e'(op))
      OP_ADD:  word = fmt_r(OPC_ADD, rm, rn, rd);
      OP_SUB:  word = fmt_r(OPC_SUB, rm, rn, rd);
      OP_AND:  word = fmt_r(OPC_AND, rm, rn, rd);
      OP_ORR:  word = fmt_r(OPC_ORR, rm, rn, rd);
      OP_LDUR: begin word = fmt_d(OPC_LDUR, imm[8:0], rn, rd); illegal = w_d_bad; end
      OP_STUR: begin word = fmt_d(OPC_STUR, imm[8:0], rn, rd); illegal = w_d_bad; end
      OP_B:    word = {OPC_B, imm};
      OP_CBZ:  begin word = fmt_cb(OPC_CBZ,  imm[18:0], rd); illegal = w_cb_bad; end
      OP_CBNZ: begin word = fmt_cb(OPC_CBNZ, imm[18:0], rd); illegal = w_cb_bad; end
      OP_ADDI: begin word = fmt_i(OPC_ADDI, imm[11:0], rn, rd); illegal = w_i_bad; end
      OP_SUBI: begin word = fmt_i(OPC_SUBI, imm[11:0], rn, rd); illegal = w_i_bad; end
      OP_ANDI: begin word = fmt_i(OPC_ANDI, imm[11:0], rn, rd); illegal = w_i_bad; end
      OP_ORRI: begin word = fmt_i(OPC_ORRI, imm[11:0], rn, rd); illegal = w_i_bad; end
      OP_END:  word = 32'h0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/legv8_instr_encoder.sv
// Program loader: streams symbolic instructions into instruction memory from base_addr.
// Define LEGV8_ENC_PAD_EN to fill the remainder of memory with NOP_WORD after END.
module legv8_instr_encoder import legv8_pkg::*; #(
  parameter int ADDR_W = 6
`ifdef LEGV8_ENC_PAD_EN
  , parameter logic [31:0] NOP_WORD = 32'h8B1F03FF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [25:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       w_word;
  logic              w_illegal;
  logic              w_fire;
  logic [ADDR_W:0]   w_wr_cnt;
  logic [ADDR_W-1:0] w_wr_addr;

  legv8_field_pack u_pack (
    .op      (in_op),
    .rd      (in_rd),
    .rn      (in_rn),
    .rm      (in_rm),
    .imm     (in_imm),
    .word    (w_word),
    .illegal (w_illegal)
  );

  assign in_ready = (r_state == S_LOAD);
`ifdef LEGV8_ENC_PAD_EN
  assign busy     = (r_state == S_LOAD) || (r_state == S_PAD);
`else
  assign busy     = (r_state == S_LOAD);
`endif
  assign w_fire   = in_valid & in_ready;

  // addr/count only advance when a write retires, so fold in the one in flight.
  assign w_wr_cnt  = count + {{ADDR_W{1'b0}}, imem_we};
  assign w_wr_addr = r_addr + {{(ADDR_W-1){1'b0}}, imem_we};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      count      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (imem_we) begin
        r_addr <= r_addr + 1'b1;
        count  <= count + 1'b1;
      end
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_addr  <= base_addr;
            count   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_fire) begin
            if (op_e'(in_op) == OP_END) begin
`ifdef LEGV8_ENC_PAD_EN
              if (w_wr_cnt == FULL) begin
                r_state <= S_DONE;
                done    <= 1'b1;
              end else begin
                r_state <= S_PAD;
              end
`else
              r_state <= S_DONE;
              done    <= 1'b1;
`endif
            end else if (w_illegal) begin
              r_state <= S_ERROR;
              err     <= 1'b1;
            end else begin
              imem_we    <= 1'b1;
              imem_addr  <= w_wr_addr;
              imem_wdata <= w_word;
              if (w_wr_cnt == LAST) begin
                r_state <= S_DONE;
                done    <= 1'b1;
              end
            end
          end
        end
`ifdef LEGV8_ENC_PAD_EN
        S_PAD: begin
          if (w_wr_cnt == FULL) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end else begin
            imem_we    <= 1'b1;
            imem_addr  <= w_wr_addr;
            imem_wdata <= NOP_WORD;
            if (w_wr_cnt == LAST) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Self-checking bench for legv8_instr_encoder (default build, padding disabled).
module tb_legv8_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [4:0]  in_rd = '0, in_rn = '0, in_rm = '0;
  logic [25:0] in_imm = '0;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, done, err;
  logic [6:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  legv8_instr_encoder #(.ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done),
    .err(err), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference encoder: builds the word from field values with plain arithmetic.
  function automatic logic [31:0] ref_word(input int op, input int rd, input int rn,
                                           input int rm, input logic [25:0] imm);
    longint u, s, w;
    u = longint'(imm);
    s = (u >= 64'd33554432) ? u - 64'd67108864 : u;
    w = 0;
    case (op)
      0:  w = 64'b10001011000 * 2097152 + rm * 65536 + rn * 32 + rd;
      1:  w = 64'b11001011000 * 2097152 + rm * 65536 + rn * 32 + rd;
      2:  w = 64'b10001010000 * 2097152 + rm * 65536 + rn * 32 + rd;
      3:  w = 64'b10101010000 * 2097152 + rm * 65536 + rn * 32 + rd;
      4:  w = 64'b11111000010 * 2097152 + ((s + 512) % 512) * 4096 + rn * 32 + rd;
      5:  w = 64'b11111000000 * 2097152 + ((s + 512) % 512) * 4096 + rn * 32 + rd;
      6:  w = 64'd5 * 67108864 + u;
      7:  w = 64'b10110100 * 16777216 + ((s + 524288) % 524288) * 32 + rd;
      8:  w = 64'b10110101 * 16777216 + ((s + 524288) % 524288) * 32 + rd;
      9:  w = 64'b1001000100 * 4194304 + u * 1024 + rn * 32 + rd;
      10: w = 64'b1101000100 * 4194304 + u * 1024 + rn * 32 + rd;
      11: w = 64'b1001001000 * 4194304 + u * 1024 + rn * 32 + rd;
      12: w = 64'b1011001000 * 4194304 + u * 1024 + rn * 32 + rd;
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  task automatic set_item(input int op, input int rd, input int rn, input int rm, input int imm);
    in_valid = 1'b1;
    in_op    = 4'(op);
    in_rd    = 5'(rd);
    in_rn    = 5'(rn);
    in_rm    = 5'(rm);
    in_imm   = 26'(imm);
  endtask

  task automatic rand_item();
    int op, imm;
    op = $urandom_range(0, 12);
    case (op)
      4, 5:        imm = int'($urandom_range(0, 511)) - 256;
      7, 8:        imm = int'($urandom_range(0, 524287)) - 262144;
      9, 10, 11, 12: imm = $urandom_range(0, 4095);
      default:     imm = $urandom;
    endcase
    set_item(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm);
  endtask

  task automatic do_start(input logic [5:0] b);
    in_valid  = 1'b0;
    start     = 1'b1;
    base_addr = b;
    tick();
    start = 1'b0;
    chk("start_ready", in_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_err", err, 0);
    chk("start_count", count, 0);
  endtask

  task automatic run_session(input logic [5:0] b, input int n, input bit gaps);
    logic [31:0] w;
    do_start(b);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin in_valid = 1'b0; tick(); end
      end
      rand_item();
      w = ref_word(int'(in_op), int'(in_rd), int'(in_rn), int'(in_rm), in_imm);
      chk("sess_ready", in_ready, 1);
      tick();
      chk("sess_we", imem_we, 1);
      chk("sess_addr", imem_addr, 32'((int'(b) + k) % 64));
      chk("sess_wdata", imem_wdata, w);
    end
    set_item(13, 0, 0, 0, 0);
    tick();
    in_valid = 1'b0;
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_ready", in_ready, 0);
    chk("end_we", imem_we, 0);
    tick();
    chk("end_count", count, 32'(n));
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_we", imem_we, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_count", count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", in_ready, 0);

    // ADD, then LDUR/CBZ back-to-back, then an illegal ADDI right behind them
    do_start(6'd0);
    set_item(0, 1, 2, 3, 0);
    tick();
    in_valid = 1'b0;
    chk("add_we", imem_we, 1);
    chk("add_addr", imem_addr, 0);
    chk("add_wdata", imem_wdata, 32'h8B030041);
    chk("add_count_pending", count, 0);
    tick();
    chk("add_we_drop", imem_we, 0);
    chk("add_count", count, 1);
    set_item(4, 5, 6, 0, 8);
    tick();
    chk("ldur_we", imem_we, 1);
    chk("ldur_addr", imem_addr, 1);
    chk("ldur_wdata", imem_wdata, 32'hF84080C5);
    set_item(7, 9, 0, 0, -2);
    tick();
    chk("cbz_we", imem_we, 1);
    chk("cbz_addr", imem_addr, 2);
    chk("cbz_wdata", imem_wdata, 32'hB4FFFFC9);
    set_item(9, 1, 1, 0, 4096);
    tick();
    in_valid = 1'b0;
    chk("addi_err", err, 1);
    chk("addi_ready", in_ready, 0);
    chk("addi_we", imem_we, 0);
    chk("addi_count", count, 3);
    tick();
    chk("addi_count_hold", count, 3);
    chk("addi_busy", busy, 0);

    // Random illegal items each drive the session to ERROR; start recovers
    for (int i = 0; i < 8; i++) begin
      do_start(6'($urandom));
      case (i % 4)
        0: set_item(14 + (i / 4), 1, 2, 3, 0);
        1: set_item(9 + int'($urandom_range(0, 3)), 1, 2, 3, 4096 + int'($urandom_range(0, 100000)));
        2: set_item(4 + int'($urandom_range(0, 1)), 1, 2, 3,
                    (i < 4) ? 256 + int'($urandom_range(0, 5000)) : -257 - int'($urandom_range(0, 5000)));
        default: set_item(7 + int'($urandom_range(0, 1)), 1, 2, 3,
                    (i < 4) ? 262144 : -262145 - int'($urandom_range(0, 9999)));
      endcase
      tick();
      in_valid = 1'b0;
      chk("ill_err", err, 1);
      chk("ill_we", imem_we, 0);
      chk("ill_ready", in_ready, 0);
    end

    // Two items then END, then a longer randomized session with idle gaps
    run_session(6'($urandom), 2, 1'b0);
    run_session(6'($urandom), 20, 1'b1);

    // Fill from base 62: wraps past 63 and stops at 64 words
    do_start(6'd62);
    for (int k = 0; k < 65; k++) begin
      logic [31:0] w;
      rand_item();
      w = ref_word(int'(in_op), int'(in_rd), int'(in_rn), int'(in_rm), in_imm);
      tick();
      if (k < 64) begin
        chk("full_we", imem_we, 1);
        chk("full_addr", imem_addr, 32'((62 + k) % 64));
        chk("full_wdata", imem_wdata, w);
      end else begin
        chk("full_extra_we", imem_we, 0);
      end
      if (k == 63) begin
        chk("full_done", done, 1);
        chk("full_ready", in_ready, 0);
      end
    end
    in_valid = 1'b0;
    tick();
    chk("full_count", count, 64);

    // Asynchronous reset while a write is on the bus
    do_start(6'd5);
    set_item(1, 3, 4, 5, 0);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_we", imem_we, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_we", imem_we, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    chk("arst_count", count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_idle_ready", in_ready, 0);
    chk("arst_idle_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
